// File: rtl/sm_pkg.sv
// Shared constants and types for the QPSK mapper: level encodings and the
// default Gray-coded mapping table.
package sm_pkg;

    localparam logic [1:0] LVL_POS = 2'b01;
    localparam logic [1:0] LVL_NEG = 2'b11;

    // One table entry: [3:2] = I level, [1:0] = Q level.
    typedef logic [3:0] map_entry_t;

    // Indexed by symbol value; the first listed element is index 3.
    localparam map_entry_t [3:0] DEFAULT_MAP = '{
        {LVL_NEG, LVL_NEG},
        {LVL_NEG, LVL_POS},
        {LVL_POS, LVL_NEG},
        {LVL_POS, LVL_POS}
    };

endpackage

// File: rtl/sm_qpsk_mapper_if.sv
// Symbol-in / level-out bundle between the serial-to-parallel converter,
// the mapper and the downstream transmit chain.
interface sm_qpsk_mapper_if;

    logic [1:0] din;
    logic       din_valid;
    logic [1:0] I_out;
    logic [1:0] Q_out;
    logic       out_valid;

    modport master (
        output din,
        output din_valid,
        input  I_out,
        input  Q_out,
        input  out_valid
    );

    modport slave (
        input  din,
        input  din_valid,
        output I_out,
        output Q_out,
        output out_valid
    );

endinterface

// File: rtl/sm_sym_counter.sv
// Single saturating occurrence counter with enable; sticks at all-ones.
// Latency 1 cycle from en to cnt; no backpressure.
module sm_sym_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (en && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sm_qpsk_mapper.sv
// QPSK mapper: programmable 4-entry symbol->(I,Q) table, optional output register.
// Latency 0 (OUT_REG=0) or 1 (OUT_REG=1); no backpressure, every valid symbol is taken.
module sm_qpsk_mapper
    import sm_pkg::*;
#(
    parameter int unsigned OUT_REG = 0,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    sm_qpsk_mapper_if.slave  bus,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic [3:0]       cfg_data,
    output logic [CNT_W-1:0] sym_cnt0,
    output logic [CNT_W-1:0] sym_cnt1,
    output logic [CNT_W-1:0] sym_cnt2,
    output logic [CNT_W-1:0] sym_cnt3
);

    map_entry_t [3:0] map_tbl;
    map_entry_t       lookup;

    // Reset wins over a same-cycle write so the table always comes back clean.
    always_ff @(posedge clk) begin
        if (rst) begin
            map_tbl <= DEFAULT_MAP;
        end else if (cfg_we) begin
            map_tbl[cfg_addr] <= cfg_data;
        end
    end

    // Reads the pre-edge table, so a same-cycle write is seen one cycle later.
    assign lookup = map_tbl[bus.din];

    generate
        if (OUT_REG == 0) begin : g_comb_out
            assign bus.I_out     = lookup[3:2];
            assign bus.Q_out     = lookup[1:0];
            assign bus.out_valid = bus.din_valid;
        end else begin : g_reg_out
            logic [1:0] i_q;
            logic [1:0] q_q;
            logic       vld_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    i_q   <= 2'b00;
                    q_q   <= 2'b00;
                    vld_q <= 1'b0;
                end else begin
                    vld_q <= bus.din_valid;
                    if (bus.din_valid) begin
                        i_q <= lookup[3:2];
                        q_q <= lookup[1:0];
                    end
                end
            end

            assign bus.I_out     = i_q;
            assign bus.Q_out     = q_q;
            assign bus.out_valid = vld_q;
        end
    endgenerate

    logic [CNT_W-1:0] cnt [4];

    generate
        for (genvar g = 0; g < 4; g++) begin : g_cnt
            sm_sym_counter #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clk (clk),
                .rst (rst),
                .en  (bus.din_valid && (bus.din == 2'(g))),
                .cnt (cnt[g])
            );
        end
    endgenerate

    assign sym_cnt0 = cnt[0];
    assign sym_cnt1 = cnt[1];
    assign sym_cnt2 = cnt[2];
    assign sym_cnt3 = cnt[3];

endmodule

// File: tb/tb_sm_qpsk_mapper.sv
// Bench for sm_qpsk_mapper: three instances (combinational, registered,
// narrow counters) driven in lockstep and checked against a table/count model.
module tb_sm_qpsk_mapper;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_we;
    logic [1:0] cfg_addr;
    logic [3:0] cfg_data;

    logic [3:0][15:0] cnt16;
    logic [3:0][15:0] cnt16_r;
    logic [3:0][3:0]  cnt4;

    sm_qpsk_mapper_if if0 ();
    sm_qpsk_mapper_if if1 ();
    sm_qpsk_mapper_if if2 ();

    sm_qpsk_mapper #(.OUT_REG(0), .CNT_W(16)) u0 (
        .clk(clk), .rst(rst), .bus(if0),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .sym_cnt0(cnt16[0]), .sym_cnt1(cnt16[1]), .sym_cnt2(cnt16[2]), .sym_cnt3(cnt16[3])
    );

    sm_qpsk_mapper #(.OUT_REG(1), .CNT_W(16)) u1 (
        .clk(clk), .rst(rst), .bus(if1),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .sym_cnt0(cnt16_r[0]), .sym_cnt1(cnt16_r[1]), .sym_cnt2(cnt16_r[2]), .sym_cnt3(cnt16_r[3])
    );

    sm_qpsk_mapper #(.OUT_REG(0), .CNT_W(4)) u2 (
        .clk(clk), .rst(rst), .bus(if2),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .sym_cnt0(cnt4[0]), .sym_cnt1(cnt4[1]), .sym_cnt2(cnt4[2]), .sym_cnt3(cnt4[3])
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: what each DUT should hold after the most recent edge.
    logic [3:0]  tbl [4];
    int unsigned cnt [4];
    logic [1:0]  ri, rq;
    logic        rv;
    bit          mdl_ok = 1'b0;

    function automatic logic [3:0] rule(input logic [1:0] s);
        return {(s[1] ? 2'b11 : 2'b01), (s[0] ? 2'b11 : 2'b01)};
    endfunction

    function automatic logic [31:0] sat(input int unsigned n, input int w);
        int unsigned mx;
        mx = (32'd1 << w) - 1;
        return (n > mx) ? mx : n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check post-edge state, apply inputs, check the
    // combinational response before the edge, then advance the model.
    task automatic drive(input logic [1:0] d, input logic v, input logic we,
                         input logic [1:0] a, input logic [3:0] dat, input logic r);
        @(negedge clk);
        if (mdl_ok) begin
            chk("u1_I", 32'(if1.I_out), 32'(ri));
            chk("u1_Q", 32'(if1.Q_out), 32'(rq));
            chk("u1_vld", 32'(if1.out_valid), 32'(rv));
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("u0_cnt%0d", i), 32'(cnt16[i]), sat(cnt[i], 16));
                chk($sformatf("u2_cnt%0d", i), 32'(cnt4[i]), sat(cnt[i], 4));
            end
        end
        if0.din = d; if1.din = d; if2.din = d;
        if0.din_valid = v; if1.din_valid = v; if2.din_valid = v;
        cfg_we = we; cfg_addr = a; cfg_data = dat; rst = r;
        #1;
        if (mdl_ok) begin
            chk("u0_IQ", 32'({if0.I_out, if0.Q_out}), 32'(tbl[d]));
            chk("u2_IQ", 32'({if2.I_out, if2.Q_out}), 32'(tbl[d]));
            chk("u0_vld", 32'(if0.out_valid), 32'(v));
        end
        if (r) begin
            for (int i = 0; i < 4; i++) begin
                tbl[i] = rule(2'(i));
                cnt[i] = 0;
            end
            ri = 2'b00; rq = 2'b00; rv = 1'b0;
            mdl_ok = 1'b1;
        end else begin
            if (v) begin
                {ri, rq} = tbl[d];
                cnt[d]++;
            end
            rv = v;
            if (we) tbl[a] = dat;
        end
    endtask

    task automatic idle();
        drive(2'b00, 1'b0, 1'b0, 2'b00, 4'h0, 1'b0);
    endtask

    initial begin
        logic [3:0] exp_dir [4];
        logic [1:0] d;
        exp_dir = '{4'b0101, 4'b0111, 4'b1101, 4'b1111};

        drive(2'b00, 1'b0, 1'b0, 2'b00, 4'h0, 1'b1);
        drive(2'b00, 1'b0, 1'b0, 2'b00, 4'h0, 1'b1);
        idle();
        chk("rst_cnt0", 32'(cnt16[0]), 32'd0);
        chk("rst_u1_IQ", 32'({if1.I_out, if1.Q_out}), 32'd0);

        // Default map, combinational, sampled before any edge
        for (int s = 0; s < 4; s++) begin
            drive(2'(s), 1'b1, 1'b0, 2'b00, 4'h0, 1'b0);
            chk($sformatf("dir_IQ%0d", s), 32'({if0.I_out, if0.Q_out}), 32'(exp_dir[s]));
        end

        // 512 random valid symbols from a clean count
        drive(2'b00, 1'b0, 1'b0, 2'b00, 4'h0, 1'b1);
        for (int n = 0; n < 512; n++) begin
            d = 2'($urandom_range(0, 3));
            drive(d, 1'b1, 1'b0, 2'b00, 4'h0, 1'b0);
            chk("rnd_I", 32'(if0.I_out), 32'(d[1] ? 2'b11 : 2'b01));
            chk("rnd_Q", 32'(if0.Q_out), 32'(d[0] ? 2'b11 : 2'b01));
        end
        idle();
        chk("cnt_sum", 32'(cnt16[0]) + 32'(cnt16[1]) + 32'(cnt16[2]) + 32'(cnt16[3]), 32'd512);

        // Table reprogram: old entry seen during the write cycle, new one after
        drive(2'b10, 1'b1, 1'b1, 2'd2, 4'b0111, 1'b0);
        chk("wr_same_cyc", 32'({if0.I_out, if0.Q_out}), 32'b1101);
        drive(2'b10, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0);
        chk("wr_new", 32'({if0.I_out, if0.Q_out}), 32'b0111);
        drive(2'b10, 1'b1, 1'b1, 2'd2, 4'b0111, 1'b1);
        drive(2'b10, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0);
        chk("wr_rst_restore", 32'({if0.I_out, if0.Q_out}), 32'b1101);

        // Registered output: capture, hold, reset
        drive(2'b11, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0);
        drive(2'b00, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0);
        chk("reg_cap", 32'({if1.I_out, if1.Q_out, if1.out_valid}), 32'b11111);
        drive(2'b01, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0);
        chk("reg_hold", 32'({if1.I_out, if1.Q_out, if1.out_valid}), 32'b11110);
        drive(2'b01, 1'b1, 1'b0, 2'd0, 4'h0, 1'b1);
        idle();
        chk("reg_rst", 32'({if1.I_out, if1.Q_out, if1.out_valid}), 32'b00000);

        // Random stream with random valid and occasional table writes
        for (int n = 0; n < 200; n++) begin
            drive(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)),
                  4'($urandom_range(0, 15)), 1'b0);
        end

        // Saturation of the narrow counters
        drive(2'b00, 1'b0, 1'b0, 2'd0, 4'h0, 1'b1);
        for (int n = 0; n < 20; n++) drive(2'b11, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0);
        idle();
        chk("sat_cnt3", 32'(cnt4[3]), 32'd15);
        chk("sat_cnt0", 32'(cnt4[0]), 32'd0);
        chk("sat_cnt2", 32'(cnt4[2]), 32'd0);
        chk("wide_cnt3", 32'(cnt16[3]), 32'd20);

        // Mid-stream reset with a competing table write
        for (int n = 0; n < 30; n++) drive(2'($urandom_range(0, 3)), 1'b1, 1'b0, 2'd0, 4'h0, 1'b0);
        drive(2'b01, 1'b1, 1'b1, 2'd1, 4'b0000, 1'b1);
        drive(2'b01, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0);
        chk("mid_rst_cnt1", 32'(cnt16[1]), 32'd0);
        chk("mid_rst_map", 32'({if0.I_out, if0.Q_out}), 32'b0111);
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
